// File: rtl/r_rr_arbiter_pkg.sv
// Shared constants and index helpers for the round-robin arbiter slice.
package r_rr_arbiter_pkg;

    localparam int RR_N_MIN = 2;
    localparam int RR_N_MAX = 16;

    // Index reached by stepping 'off' places above 'base' in a ring of n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    function automatic bit rr_n_legal(input int n);
        return (n >= RR_N_MIN) && (n <= RR_N_MAX);
    endfunction

endpackage

// File: rtl/r_reg.sv
// Generic enabled register; clock edge and reset style come from reusables.vh.
`include "reusables.vh"

module r_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam bit CLK_RISING  = (`REUSABLES_REG_CLK_RISING != 0);
    localparam bit ACTIVE_HIGH = (`REUSABLES_REG_RESET_ACTIVE_HIGH != 0);
    localparam bit RESET_SYNC  = (`REUSABLES_REG_RESET_SYNC != 0);

    logic rst_act;
    assign rst_act = ACTIVE_HIGH ? reset : !reset;

    generate
        if (CLK_RISING && RESET_SYNC) begin : g_rise_sync
            always_ff @(posedge clk) begin
                if (rst_act)
                    q <= RST_VAL;
                else if (en)
                    q <= d;
            end
        end else if (CLK_RISING) begin : g_rise_async
            always_ff @(posedge clk or posedge rst_act) begin
                if (rst_act)
                    q <= RST_VAL;
                else if (en)
                    q <= d;
            end
        end else if (RESET_SYNC) begin : g_fall_sync
            always_ff @(negedge clk) begin
                if (rst_act)
                    q <= RST_VAL;
                else if (en)
                    q <= d;
            end
        end else begin : g_fall_async
            always_ff @(negedge clk or posedge rst_act) begin
                if (rst_act)
                    q <= RST_VAL;
                else if (en)
                    q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/r_rr_pick.sv
// Combinational round-robin pick: first valid index strictly above ptr, with wrap.
import r_rr_arbiter_pkg::*;

module r_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // ptr itself is visited last, so the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin : l_scan
            int i;
            i = rr_wrap(int'(ptr), k, N);
            if (!any && valid[i]) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reusables.vh
// Shared helpers for the reusables library: register build options,
// ceil-log2 helper and the round-robin reset pointer constant.
`ifndef REUSABLES_VH
`define REUSABLES_VH

`ifndef REUSABLES_REG_CLK_RISING
`define REUSABLES_REG_CLK_RISING 1
`endif

`ifndef REUSABLES_REG_RESET_ACTIVE_HIGH
`define REUSABLES_REG_RESET_ACTIVE_HIGH 1
`endif

`ifndef REUSABLES_REG_RESET_SYNC
`define REUSABLES_REG_RESET_SYNC 1
`endif

// Never returns 0, so a width derived from it is always legal.
`define REUSABLES_CLOG2(n) (((n) <= 1) ? 1 : $clog2(n))

// Pointer value that makes index 0 the first winner after reset.
`define REUSABLES_RR_RESET_PTR(n) ((n) - 1)

`endif

// File: rtl/r_rr_arbiter.sv
// N-to-1 round-robin arbiter feeding a single registered output slot.
`include "reusables.vh"
import r_rr_arbiter_pkg::*;

module r_rr_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = `REUSABLES_CLOG2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_id,
    input  logic           out_ready
);

    localparam logic [IW-1:0] PTR_RST = IW'(`REUSABLES_RR_RESET_PTR(N));
    localparam bit            N_OK    = rr_n_legal(N);

    logic [IW-1:0] ptr_p1;
    logic [N-1:0]  grant_p0;
    logic [IW-1:0] gnt_idx_p0;
    logic          any_p0;
    logic          accept_en_p0;
    logic          accept_p0;
    logic [W-1:0]  sel_data_p0;

    // Stage 0: combinational grant against the current slot state.
    r_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_p1),
        .grant (grant_p0),
        .idx   (gnt_idx_p0),
        .any   (any_p0)
    );

    assign accept_en_p0 = !out_valid || out_ready;
    assign accept_p0    = N_OK && any_p0 && accept_en_p0 && !reset;
    assign req_ready    = accept_p0 ? grant_p0 : '0;

    // Mux keyed by the one-hot grant so the handshake never sees payload bits.
    always_comb begin
        sel_data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_p0[i])
                sel_data_p0 = sel_data_p0 | req_data[i*W +: W];
        end
    end

    // Stage 1: slot and pointer registers.
    r_reg #(
        .W       (IW),
        .RST_VAL (PTR_RST)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (accept_p0),
        .d     (gnt_idx_p0),
        .q     (ptr_p1)
    );

    // Loaded on every cycle the slot may change: refilled on accept, emptied on drain.
    r_reg #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_valid (
        .clk   (clk),
        .reset (reset),
        .en    (accept_en_p0),
        .d     (accept_p0),
        .q     (out_valid)
    );

    r_reg #(
        .W       (W),
        .RST_VAL ('0)
    ) u_data (
        .clk   (clk),
        .reset (reset),
        .en    (accept_p0),
        .d     (sel_data_p0),
        .q     (out_data)
    );

    r_reg #(
        .W       (IW),
        .RST_VAL ('0)
    ) u_id (
        .clk   (clk),
        .reset (reset),
        .en    (accept_p0),
        .d     (gnt_idx_p0),
        .q     (out_id)
    );

endmodule
